// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline stages and the central step controller.
// The sequencer uses the slave modport; the stage side (or a testbench) uses master.
interface pipeline_sequencer_if #(
    parameter int NSTAGES = 5,
    parameter int CNT_W   = 32
);
    logic [NSTAGES-1:0] stage_ok;
    logic [NSTAGES-1:0] stage_valid;
    logic               jump_en;
    logic [63:0]        jump_addr;
    logic               halt_req;
    logic               ok_to_proceed_overall;
    logic [NSTAGES-1:0] flush;
    logic               redirect_en;
    logic [63:0]        redirect_addr;
    logic               halted;
    logic               timeout;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output stage_ok, stage_valid, jump_en, jump_addr, halt_req,
        input  ok_to_proceed_overall, flush, redirect_en, redirect_addr,
               halted, timeout, stall_cnt
    );

    modport slave (
        input  stage_ok, stage_valid, jump_en, jump_addr, halt_req,
        output ok_to_proceed_overall, flush, redirect_en, redirect_addr,
               halted, timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Central step controller: issues one global advance pulse per RUN/ADV/SETTLE round,
// turns writeback jumps into flush+redirect, drains to HALT and tracks stalls.
module pipeline_sequencer #(
    parameter int NSTAGES = 5,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipeline_sequencer_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [NSTAGES-1:0] JUMP_MASK = {1'b0, {(NSTAGES-1){1'b1}}};

    typedef enum logic [1:0] {RUN, ADV, SETTLE, HALT} state_t;

    state_t             r_state,   w_state;
    logic               r_drain,   w_drain;
    logic               r_ok,      w_ok;
    logic [NSTAGES-1:0] r_flush,   w_flush;
    logic               r_redir,   w_redir;
    logic [63:0]        r_raddr,   w_raddr;
    logic               r_halted,  w_halted;
    logic               r_timeout, w_timeout;
    logic [CNT_W-1:0]   r_stall,   w_stall;
    logic [WAIT_W-1:0]  r_wait,    w_wait;
    logic               w_allOk;

    assign w_allOk = &bus.stage_ok;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state;
    end

    // Outputs are computed from the transition so they appear in the cycle of the target state.
    always_comb begin
        w_state   = r_state;
        w_drain   = r_drain;
        w_ok      = 1'b0;
        w_flush   = '0;
        w_redir   = 1'b0;
        w_raddr   = '0;
        w_halted  = r_halted;
        w_timeout = r_timeout;
        w_stall   = r_stall;
        w_wait    = r_wait;
        case (r_state)
            RUN: begin
                if (w_allOk) begin
                    w_drain = r_drain | bus.halt_req;
                    if (r_drain && (bus.stage_valid == '0)) begin
                        w_state  = HALT;
                        w_halted = 1'b1;
                    end else begin
                        w_state = ADV;
                        w_ok    = 1'b1;
                        if (bus.jump_en) begin
                            w_flush = JUMP_MASK;
                            w_redir = 1'b1;
                            w_raddr = bus.jump_addr;
                        end
                        if (w_drain) w_flush[0] = 1'b1;
                    end
                end else begin
                    if (r_stall != '1) w_stall = r_stall + CNT_W'(1);
                    if (r_wait != WAIT_W'(TIMEOUT)) w_wait = r_wait + WAIT_W'(1);
                    if (w_wait == WAIT_W'(TIMEOUT)) w_timeout = 1'b1;
                end
            end
            ADV: begin
                w_wait  = '0;
                w_state = SETTLE;
            end
            SETTLE: w_state = RUN;
            HALT: begin
                if (!bus.halt_req) begin
                    w_state  = RUN;
                    w_drain  = 1'b0;
                    w_halted = 1'b0;
                end
            end
            default: w_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain   <= 1'b0;
            r_ok      <= 1'b0;
            r_flush   <= '0;
            r_redir   <= 1'b0;
            r_raddr   <= '0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_stall   <= '0;
            r_wait    <= '0;
        end else begin
            r_drain   <= w_drain;
            r_ok      <= w_ok;
            r_flush   <= w_flush;
            r_redir   <= w_redir;
            r_raddr   <= w_raddr;
            r_halted  <= w_halted;
            r_timeout <= w_timeout;
            r_stall   <= w_stall;
            r_wait    <= w_wait;
        end
    end

    assign bus.ok_to_proceed_overall = r_ok;
    assign bus.flush                 = r_flush;
    assign bus.redirect_en           = r_redir;
    assign bus.redirect_addr         = r_raddr;
    assign bus.halted                = r_halted;
    assign bus.timeout               = r_timeout;
    assign bus.stall_cnt             = r_stall;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus random traffic
// compared each cycle against a cycle-scheduled behavioural model.
module tb_pipeline_sequencer;
    localparam int NSTAGES = 5;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 6;
    localparam logic [NSTAGES-1:0] ALL_OK = '1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipeline_sequencer_if #(.NSTAGES(NSTAGES), .CNT_W(CNT_W)) ifc ();

    pipeline_sequencer #(.NSTAGES(NSTAGES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Model: cycle numbers decide when RUN may evaluate; expectations are for the current cycle.
    int               mCycle, mNextEval, mWait;
    bit               mDrain, mHalted, mTimeout;
    int               mStall;
    logic             expOk, expRedir, expHalted, expTimeout;
    logic [NSTAGES-1:0] expFlush;
    logic [63:0]      expAddr;
    logic [CNT_W-1:0] expStall;

    task automatic modelReset();
        mCycle = 0; mNextEval = 0; mWait = 0; mStall = 0;
        mDrain = 0; mHalted = 0; mTimeout = 0;
        expOk = 0; expRedir = 0; expHalted = 0; expTimeout = 0;
        expFlush = '0; expAddr = '0; expStall = '0;
    endtask

    task automatic modelUpdate();
        expOk = 0; expFlush = '0; expRedir = 0; expAddr = '0;
        if (mHalted) begin
            if (!ifc.halt_req) begin
                mHalted = 0; mDrain = 0; mNextEval = mCycle + 1;
            end
        end else if (mCycle >= mNextEval) begin
            if (ifc.stage_ok == ALL_OK) begin
                if (mDrain && ifc.stage_valid == '0) begin
                    mHalted = 1;
                end else begin
                    mDrain = mDrain | ifc.halt_req;
                    expOk = 1;
                    if (ifc.jump_en) begin
                        expFlush = NSTAGES'((1 << (NSTAGES - 1)) - 1);
                        expRedir = 1;
                        expAddr  = ifc.jump_addr;
                    end
                    if (mDrain) expFlush[0] = 1'b1;
                    mWait = 0;
                    mNextEval = mCycle + 3;
                end
            end else begin
                if (mStall < (1 << CNT_W) - 1) mStall++;
                if (mWait < TIMEOUT) mWait++;
                if (mWait == TIMEOUT) mTimeout = 1;
            end
        end
        expHalted  = mHalted;
        expTimeout = mTimeout;
        expStall   = CNT_W'(mStall);
        mCycle++;
    endtask

    task automatic checkOutput();
        checks++;
        assert (ifc.ok_to_proceed_overall === expOk) else begin
            errors++;
            $error("[TB] FAIL pulse cyc %0d observed %b expected %b", mCycle, ifc.ok_to_proceed_overall, expOk);
        end
        checks++;
        assert (ifc.flush === expFlush) else begin
            errors++;
            $error("[TB] FAIL flush cyc %0d observed %b expected %b", mCycle, ifc.flush, expFlush);
        end
        checks++;
        assert (ifc.redirect_en === expRedir) else begin
            errors++;
            $error("[TB] FAIL redirect_en cyc %0d observed %b expected %b", mCycle, ifc.redirect_en, expRedir);
        end
        checks++;
        assert (ifc.redirect_addr === expAddr) else begin
            errors++;
            $error("[TB] FAIL redirect_addr cyc %0d observed %h expected %h", mCycle, ifc.redirect_addr, expAddr);
        end
        checks++;
        assert (ifc.halted === expHalted) else begin
            errors++;
            $error("[TB] FAIL halted cyc %0d observed %b expected %b", mCycle, ifc.halted, expHalted);
        end
        checks++;
        assert (ifc.timeout === expTimeout) else begin
            errors++;
            $error("[TB] FAIL timeout cyc %0d observed %b expected %b", mCycle, ifc.timeout, expTimeout);
        end
        checks++;
        assert (ifc.stall_cnt === expStall) else begin
            errors++;
            $error("[TB] FAIL stall_cnt cyc %0d observed %0d expected %0d", mCycle, ifc.stall_cnt, expStall);
        end
    endtask

    // One cycle: check current outputs mid-cycle, advance the model, then cross the clock edge.
    task automatic step();
        @(negedge clk);
        checkOutput();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NSTAGES-1:0] ok, input logic [NSTAGES-1:0] valid,
                                 input logic jmp, input logic [63:0] addr, input logic halt);
        ifc.stage_ok    = ok;
        ifc.stage_valid = valid;
        ifc.jump_en     = jmp;
        ifc.jump_addr   = addr;
        ifc.halt_req    = halt;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic waitEval();
        for (int i = 0; i < 4 && !(mCycle >= mNextEval && !mHalted); i++) step();
    endtask

    initial begin
        logic [NSTAGES-1:0] valid;
        applyStimulus(ALL_OK, '1, 1'b0, 64'd0, 1'b0);
        doReset();
        $display("[TB] free-running advance");
        for (int i = 0; i < 9; i++) step();

        $display("[TB] stall then recover");
        applyStimulus(5'b01111, '1, 1'b0, 64'd0, 1'b0);
        waitEval();
        for (int i = 0; i < 4; i++) step();
        applyStimulus(ALL_OK, '1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        $display("[TB] jump redirect");
        waitEval();
        applyStimulus(ALL_OK, '1, 1'b1, 64'h0000_0000_8000_0040, 1'b0);
        step();
        applyStimulus(ALL_OK, '1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) step();

        $display("[TB] drain to halt");
        valid = '1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(ALL_OK, valid, 1'b0, 64'd0, 1'b1);
            step();
            valid = {valid[NSTAGES-2:0], 1'b0};
        end
        applyStimulus(ALL_OK, '1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 6; i++) step();

        $display("[TB] watchdog and saturation");
        waitEval();
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus('0, '1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0);
            step();
        end
        applyStimulus(ALL_OK, '1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        applyStimulus(5'b11011, '1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 70; i++) step();
        applyStimulus(ALL_OK, '1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7) ? ALL_OK : NSTAGES'($urandom),
                          NSTAGES'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                          1'($urandom_range(0, 3) == 0), {$urandom, $urandom},
                          1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 79) == 0) doReset();
            step();
        end

        $display("[TB] reset during advance");
        applyStimulus(ALL_OK, '1, 1'b1, 64'h1234, 1'b0);
        for (int i = 0; i < 12 && !expOk; i++) step();
        checks++;
        assert (expOk === 1'b1 && ifc.ok_to_proceed_overall === 1'b1) else begin
            errors++;
            $error("[TB] FAIL reach_adv observed %b expected 1", ifc.ok_to_proceed_overall);
        end
        doReset();
        for (int i = 0; i < 5; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central step controller for the in-order pipeline. It collects each stage's ready flag (`ok_to_proceed`) and generates the single global advance pulse (`ok_to_proceed_overall`) that every stage, writeback included, samples. It also turns writeback's jump request into a flush of the younger stages plus a PC redirect. It drains and halts the pipeline on request and keeps stall and timeout diagnostics.

## Interface
Parameters:
- `NSTAGES`, default 5: number of pipeline stages. Bit 0 is fetch; bit NSTAGES-1 is writeback.
- `TIMEOUT`, default 1024: consecutive stall cycles after which `timeout` sets.
- `CNT_W`, default 32: width of `stall_cnt`.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `stage_ok`  in  NSTAGES  bit i is stage i's `ok_to_proceed`.
- `stage_valid`  in  NSTAGES  bit i means stage i holds a valid instruction.
- `jump_en`  in  1  jump or taken branch resolved in writeback, already valid-qualified.
- `jump_addr`  in  64  target address; meaningful only when `jump_en` is high.
- `halt_req`  in  1  level request to drain and stop.
- `ok_to_proceed_overall`  out  1  global advance pulse.
- `flush`  out  NSTAGES  invalidate mask, applied with the advance.
- `redirect_en`  out  1  load the PC with `redirect_addr`.
- `redirect_addr`  out  64  redirect target.
- `halted`  out  1  pipeline is empty and stopped.
- `timeout`  out  1  sticky watchdog flag.
- `stall_cnt`  out  CNT_W  total stall cycles, saturating.

## Operation
- All outputs are registered.
- FSM states:
  - RUN: evaluates `stage_ok`.
  - ADV: outputs the advance pulse.
  - SETTLE: one dead cycle while the stages re-arm `ok_to_proceed`.
  - HALT: stopped.
- A `drain` flag register qualifies RUN and ADV.
- RUN, when all `stage_ok` bits are 1 (`&stage_ok`):
  - If `drain` is set and `stage_valid` is 0, go to HALT.
  - Otherwise go to ADV.
  - Latch `jump_en` and `jump_addr`.
  - Set `drain` if `halt_req` is high.
- RUN, when `&stage_ok` is 0:
  - Stay in RUN.
  - Increment `stall_cnt`, saturating at all-ones.
  - Increment the wait counter; when it reaches TIMEOUT, set `timeout`.
  - `timeout` is cleared only by `rst`.
- ADV lasts exactly one cycle:
  - `ok_to_proceed_overall`=1.
  - If the latched jump is set: `flush` = all stages except NSTAGES-1, `redirect_en`=1, `redirect_addr` = latched `jump_addr`.
  - If `drain` is set: additionally set `flush[0]`=1 so no new instruction enters.
  - Clear the wait counter.
  - Next state is SETTLE.
- SETTLE: all pulse outputs are 0, `stage_ok` is ignored and no stall is counted. Next state is RUN.
- HALT:
  - `halted`=1 and no advance is issued.
  - When `halt_req`=0, clear `drain` and `halted` and go to RUN.
- `jump_en` is sampled only in RUN when `&stage_ok` is 1. Values at any other time are ignored.

## Timing
- Reset values, taking effect on the first clock edge with `rst`=1: state=RUN, `drain`=0, `ok_to_proceed_overall`=0, `flush`=0, `redirect_en`=0, `redirect_addr`=0, `halted`=0, `timeout`=0, `stall_cnt`=0, wait counter=0.
- `rst` overrides every transition, including during an ADV cycle. No pulse is emitted in the cycle after reset.
- Latency: RUN sees all ready at cycle t, then ADV at t+1 (pulse high), SETTLE at t+2, RUN evaluates again at t+3.
  - Maximum rate is one advance per 3 cycles.
  - Advance pulses are never back-to-back.
- `flush`, `redirect_en` and `redirect_addr` are valid only in the same cycle as the `ok_to_proceed_overall` pulse and are 0 otherwise.
- Jump and halt in the same RUN cycle: the redirect and flush are applied in that ADV cycle and `drain` is set. The redirect fetch is then suppressed by `flush[0]` on later advances.
- `halt_req` deasserted before HALT is reached: `drain` stays set and the pipeline still drains to HALT. It then leaves HALT on the next cycle.
- `stall_cnt` stops at 2^CNT_W-1 and never wraps. The wait counter saturates at TIMEOUT.

## Test plan
- Reset, then `stage_ok`=all-ones held: pulses at cycles 1, 4, 7, ...; `flush`=0; `stall_cnt`=0.
- `stage_ok`=5'b01111 for 4 cycles, then all-ones: `stall_cnt`=4, then the pulse occurs 1 cycle after `stage_ok` goes all-ones.
- `jump_en`=1 with `jump_addr`=0x8000_0040 while all ready: the next cycle shows the pulse with `flush`=5'b01111, `redirect_en`=1, `redirect_addr`=0x8000_0040.
- `halt_req`=1 with `stage_valid` stepping 5'b11111, then shifting to 0: every pulse has `flush[0]`=1; `halted`=1 after `stage_valid`=0; drop `halt_req` and `halted`=0 the next cycle, with advances resuming.
- TIMEOUT=8, `stage_ok`=0 for 8 cycles: `timeout`=1 and stays set after `stage_ok` recovers, until `rst`.
- `rst` asserted during an ADV cycle: the next cycle has all outputs 0 and state RUN.
